dmem_access_unit: RTL and testbench

Memory-stage access unit sitting between the EX/MEM pipeline register and the MEM/WB register. It consumes the EX/MEM control and data bundle, runs a req/ack handshake with a variable-latency data memory, and stalls the upstream pipeline while an access is outstanding. It also registers the MEM/WB bundle, inserting bubbles during stalls and aborting hung accesses after a bounded wait.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_wait_timer.sv | 31 +++
 rtl/dmem_access_unit.sv | 188 ++++++++++++++++++
 tb/tb_dmem_access_unit.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access unit.
// The access FSM state enum, the default abort bound, the bubble values loaded
// into MEM/WB and the word-alignment mask all live here.
package dmem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } dmem_state_e;

    localparam int unsigned DEFAULT_MAX_WAIT = 16;

    localparam logic        BUBBLE_REG_WRITE  = 1'b0;
    localparam logic        BUBBLE_MEM_TO_REG = 1'b0;
    localparam logic [31:0] BUBBLE_DATA       = 32'h0000_0000;
    localparam logic [4:0]  BUBBLE_RD         = 5'd0;

    localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

    // True when the address is not on a 32-bit word boundary.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr & ~ADDR_ALIGN_MASK) != 32'h0;
    endfunction

endpackage

// File: rtl/dmem_wait_timer.sv
// Counts cycles spent waiting in REQ and flags the last cycle allowed before
// the access is abandoned. The count saturates so it can never wrap back into
// a non-expired value.
module dmem_wait_timer
    import dmem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam logic [7:0] LAST_CYCLE = 8'(MAX_WAIT - 1);

    logic [7:0] cnt_q;

    // Wait counter: cleared outside REQ, advances on each unacknowledged REQ cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            cnt_q <= 8'd0;
        end else if (count && (cnt_q != 8'hFF)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign expired = (cnt_q == LAST_CYCLE);

endmodule

// File: rtl/dmem_access_unit.sv
// Memory-stage access unit: takes the EX/MEM bundle, runs a req/ack handshake
// with a variable-latency data memory, stalls upstream while an access is
// outstanding and registers the MEM/WB bundle (bubbles while stalled).
// Optional feature macro: DMEM_ALIGN_CHECK_EN rejects misaligned accesses with
// an error pulse; without it the low address bits are simply dropped.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic        MemToReg_i,
    input  logic        RegWrite_i,
    input  logic [31:0] ALUOut_i,
    input  logic [31:0] mux7_i,
    input  logic [4:0]  mux8_i,
    output logic        stall_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        RegWrite_o,
    output logic        MemToReg_o,
    output logic [31:0] ALUOut_o,
    output logic [31:0] ReadData_o,
    output logic [4:0]  RegDst_o
);

    dmem_state_e state_q, state_d;

    logic access;
    logic misaligned;
    logic start_req;
    logic complete;
    logic abort;
    logic timer_expired;
    logic in_req;

    logic        we_q;
    logic        reg_write_q;
    logic        mem_to_reg_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;

    logic        err_q;
    logic        wb_reg_write_q;
    logic        wb_mem_to_reg_q;
    logic [31:0] wb_alu_out_q;
    logic [31:0] wb_read_data_q;
    logic [4:0]  wb_rd_q;

    assign access = MemRead_i | MemWrite_i;
    assign in_req = (state_q == REQ);

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = access && is_misaligned(ALUOut_i);
`else
    assign misaligned = 1'b0;
`endif

    dmem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (!in_req),
        .count   (in_req && !mem_ack_i),
        .expired (timer_expired)
    );

    // Next-state and stall decode: stall while an access is starting or still waiting.
    always_comb begin
        state_d   = state_q;
        stall_o   = 1'b0;
        start_req = 1'b0;
        complete  = 1'b0;
        abort     = 1'b0;
        case (state_q)
            IDLE: begin
                if (access && !misaligned) begin
                    stall_o   = 1'b1;
                    start_req = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (mem_ack_i) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else if (timer_expired) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the EX/MEM bundle when a request starts; a write beats a read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q         <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            rd_q         <= 5'd0;
        end else if (start_req) begin
            we_q         <= MemWrite_i;
            reg_write_q  <= RegWrite_i;
            mem_to_reg_q <= MemToReg_i;
            addr_q       <= ALUOut_i;
            wdata_q      <= mux7_i;
            rd_q         <= mux8_i;
        end
    end

    // MEM/WB register: pass-through for non-memory ops, result on ack, bubble otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_reg_write_q  <= BUBBLE_REG_WRITE;
            wb_mem_to_reg_q <= BUBBLE_MEM_TO_REG;
            wb_alu_out_q    <= BUBBLE_DATA;
            wb_read_data_q  <= BUBBLE_DATA;
            wb_rd_q         <= BUBBLE_RD;
        end else if (complete) begin
            wb_reg_write_q  <= reg_write_q;
            wb_mem_to_reg_q <= mem_to_reg_q;
            wb_alu_out_q    <= addr_q;
            wb_read_data_q  <= we_q ? BUBBLE_DATA : mem_rdata_i;
            wb_rd_q         <= rd_q;
        end else if ((state_q == IDLE) && !access) begin
            wb_reg_write_q  <= RegWrite_i;
            wb_mem_to_reg_q <= MemToReg_i;
            wb_alu_out_q    <= ALUOut_i;
            wb_read_data_q  <= BUBBLE_DATA;
            wb_rd_q         <= mux8_i;
        end else begin
            wb_reg_write_q  <= BUBBLE_REG_WRITE;
            wb_mem_to_reg_q <= BUBBLE_MEM_TO_REG;
            wb_alu_out_q    <= BUBBLE_DATA;
            wb_read_data_q  <= BUBBLE_DATA;
            wb_rd_q         <= BUBBLE_RD;
        end
    end

    // One-cycle error pulse after a timeout abort or a rejected misaligned access.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= abort || ((state_q == IDLE) && misaligned);
        end
    end

    assign err_o       = err_q;
    assign mem_req_o   = in_req;
    assign mem_we_o    = in_req && we_q;
    assign mem_addr_o  = in_req ? (addr_q & ADDR_ALIGN_MASK) : 32'h0;
    assign mem_wdata_o = in_req ? wdata_q : 32'h0;

    assign RegWrite_o = wb_reg_write_q;
    assign MemToReg_o = wb_mem_to_reg_q;
    assign ALUOut_o   = wb_alu_out_q;
    assign ReadData_o = wb_read_data_q;
    assign RegDst_o   = wb_rd_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit. Expected MEM/WB contents, stall,
// request and error behaviour are derived per transaction from its parameters
// (op kind, address, data, which REQ cycle the ack arrives in).
// Honours DMEM_ALIGN_CHECK_EN when it is defined for the build.
module tb_dmem_access_unit;

    localparam int MAXW = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i, MemWrite_i, MemToReg_i, RegWrite_i;
    logic [31:0] ALUOut_i, mux7_i;
    logic [4:0]  mux8_i;
    logic        stall_o, err_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        RegWrite_o, MemToReg_o;
    logic [31:0] ALUOut_o, ReadData_o;
    logic [4:0]  RegDst_o;

    int vectors = 0;
    int miscompares = 0;

    // Expected MEM/WB bundle {RegWrite, MemToReg, ALUOut, ReadData, RegDst} and err_o
    // for the cycle following the most recent clock edge.
    logic [70:0] exp_wb;
    logic        exp_err;
    logic [70:0] act_wb;

    assign act_wb = {RegWrite_o, MemToReg_o, ALUOut_o, ReadData_o, RegDst_o};

    dmem_access_unit #(
        .MAX_WAIT (MAXW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .MemToReg_i  (MemToReg_i),
        .RegWrite_i  (RegWrite_i),
        .ALUOut_i    (ALUOut_i),
        .mux7_i      (mux7_i),
        .mux8_i      (mux8_i),
        .stall_o     (stall_o),
        .err_o       (err_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .RegWrite_o  (RegWrite_o),
        .MemToReg_o  (MemToReg_o),
        .ALUOut_o    (ALUOut_o),
        .ReadData_o  (ReadData_o),
        .RegDst_o    (RegDst_o)
    );

    always #5 clk_i = ~clk_i;

    // Present a non-memory op for one cycle; checks the previous result on the way in.
    task automatic run_alu(input string name, input logic rw, input logic mtr,
                           input logic [31:0] alu, input logic [4:0] rd, input logic ack_noise);
        @(negedge clk_i);
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        RegWrite_i  = rw;
        MemToReg_i  = mtr;
        ALUOut_i    = alu;
        mux7_i      = $urandom;
        mux8_i      = rd;
        mem_ack_i   = ack_noise;
        mem_rdata_i = $urandom;
        #1;
        vectors++;
        if (act_wb !== exp_wb) begin
            miscompares++;
            $display("[TB] FAIL %s memwb: got %h want %h", name, act_wb, exp_wb);
        end
        vectors++;
        if ({err_o, stall_o, mem_req_o, mem_we_o} !== {exp_err, 3'b000}) begin
            miscompares++;
            $display("[TB] FAIL %s err/stall/req/we: got %b want %b", name,
                     {err_o, stall_o, mem_req_o, mem_we_o}, {exp_err, 3'b000});
        end
        exp_wb  = {rw, mtr, alu, 32'h0, rd};
        exp_err = 1'b0;
    endtask

    // Present a memory op and play the memory side; ack_at is the REQ cycle (1-based)
    // carrying the ack, 0 or anything above MAXW means the memory never answers.
    task automatic run_mem(input string name, input logic mr, input logic mw,
                           input logic rw, input logic mtr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] rd,
                           input int ack_at, input logic [31:0] rdata);
        logic        done;
        logic        we;
        logic        exp_stall;
        logic [96:0] exp_port;
        done = 1'b0;
        we   = mw;
        @(negedge clk_i);
        MemRead_i   = mr;
        MemWrite_i  = mw;
        RegWrite_i  = rw;
        MemToReg_i  = mtr;
        ALUOut_i    = addr;
        mux7_i      = wd;
        mux8_i      = rd;
        mem_ack_i   = 1'($urandom);
        mem_rdata_i = $urandom;
        #1;
        vectors++;
        if (act_wb !== exp_wb) begin
            miscompares++;
            $display("[TB] FAIL %s memwb at issue: got %h want %h", name, act_wb, exp_wb);
        end
        vectors++;
        if (err_o !== exp_err) begin
            miscompares++;
            $display("[TB] FAIL %s err at issue: got %b want %b", name, err_o, exp_err);
        end
`ifdef DMEM_ALIGN_CHECK_EN
        if (addr[1:0] != 2'b00) begin
            vectors++;
            if ({stall_o, mem_req_o} !== 2'b00) begin
                miscompares++;
                $display("[TB] FAIL %s misaligned stall/req: got %b want 00", name,
                         {stall_o, mem_req_o});
            end
            exp_wb  = '0;
            exp_err = 1'b1;
            return;
        end
`endif
        vectors++;
        if ({stall_o, mem_req_o} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL %s issue stall/req: got %b want 10", name, {stall_o, mem_req_o});
        end
        exp_wb  = '0;
        exp_err = 1'b0;
        for (int i = 1; i <= MAXW; i++) begin
            @(negedge clk_i);
            MemRead_i   = 1'($urandom);
            MemWrite_i  = 1'($urandom);
            RegWrite_i  = 1'($urandom);
            MemToReg_i  = 1'($urandom);
            ALUOut_i    = $urandom;
            mux7_i      = $urandom;
            mux8_i      = 5'($urandom);
            mem_ack_i   = (i == ack_at);
            mem_rdata_i = (i == ack_at) ? rdata : $urandom;
            #1;
            exp_stall = (i != ack_at) && (i != MAXW);
            exp_port  = {1'b1, we, addr & 32'hFFFF_FFFC, wd};
            vectors++;
            if (act_wb !== exp_wb) begin
                miscompares++;
                $display("[TB] FAIL %s memwb req%0d: got %h want %h", name, i, act_wb, exp_wb);
            end
            vectors++;
            if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== exp_port) begin
                miscompares++;
                $display("[TB] FAIL %s mem port req%0d: got %h want %h", name, i,
                         {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}, exp_port);
            end
            vectors++;
            if ({stall_o, err_o} !== {exp_stall, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL %s stall/err req%0d: got %b want %b", name, i,
                         {stall_o, err_o}, {exp_stall, 1'b0});
            end
            if (i == ack_at) begin
                exp_wb  = {rw, mtr, addr, (we ? 32'h0 : rdata), rd};
                exp_err = 1'b0;
                done    = 1'b1;
                break;
            end
        end
        if (!done) begin
            exp_wb  = '0;
            exp_err = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_i       = 1'b1;
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        RegWrite_i  = 1'b0;
        MemToReg_i  = 1'b0;
        ALUOut_i    = 32'h0;
        mux7_i      = 32'h0;
        mux8_i      = 5'd0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        vectors++;
        if ({act_wb, err_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset outputs: got wb=%h err=%b stall=%b req=%b we=%b addr=%h wd=%h want all 0",
                     act_wb, err_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
        end
        rst_i   = 1'b0;
        exp_wb  = '0;
        exp_err = 1'b0;
    endtask

    task automatic test_alu_op();
        run_alu("alu_1234", 1'b1, 1'b0, 32'h0000_1234, 5'd5, 1'b0);
        run_alu("alu_rand", 1'($urandom), 1'b0, $urandom, 5'($urandom), 1'b1);
    endtask

    task automatic test_load();
        run_mem("load_100", 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, $urandom, 5'd9, 3, 32'hDEAD_BEEF);
        run_mem("load_last", 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0104, $urandom, 5'd10, MAXW, 32'h1357_9BDF);
    endtask

    task automatic test_store();
        run_mem("store_200", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 5'd3, 1, $urandom);
        run_mem("read_write", 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'h0BAD_CAFE, 5'd4, 2, 32'hFFFF_FFFF);
    endtask

    task automatic test_timeout();
        run_mem("timeout", 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0400, $urandom, 5'd6, 0, $urandom);
        run_alu("late_ack", 1'b1, 1'b0, 32'h0000_0055, 5'd7, 1'b1);
        run_alu("after_timeout", 1'b0, 1'b0, 32'h0000_0066, 5'd8, 1'b0);
    endtask

    task automatic test_reset_mid_req();
        run_alu("pre_reset", 1'b1, 1'b0, 32'h0000_0077, 5'd1, 1'b0);
        @(negedge clk_i);
        MemRead_i   = 1'b1;
        MemWrite_i  = 1'b0;
        RegWrite_i  = 1'b1;
        MemToReg_i  = 1'b1;
        ALUOut_i    = 32'h0000_0500;
        mux8_i      = 5'd2;
        mem_ack_i   = 1'b0;
        #1;
        vectors++;
        if ({act_wb, stall_o} !== {exp_wb, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL rst_mid issue: got %h/%b want %h/1", act_wb, stall_o, exp_wb);
        end
        @(negedge clk_i);
        MemRead_i = 1'b0;
        #1;
        vectors++;
        if (mem_req_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rst_mid req1: got %b want 1", mem_req_o);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i       = 1'b0;
        RegWrite_i  = 1'b1;
        MemToReg_i  = 1'b0;
        ALUOut_i    = 32'h0000_0088;
        mux8_i      = 5'd11;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h1111_2222;
        #1;
        vectors++;
        if ({act_wb, err_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== '0) begin
            miscompares++;
            $display("[TB] FAIL rst_mid outputs: got wb=%h err=%b stall=%b req=%b want all 0",
                     act_wb, err_o, stall_o, mem_req_o);
        end
        exp_wb  = {1'b1, 1'b0, 32'h0000_0088, 32'h0, 5'd11};
        exp_err = 1'b0;
        run_mem("after_rst", 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0600, $urandom, 5'd12, 2, 32'hA5A5_5A5A);
    endtask

    task automatic test_misaligned();
        run_mem("misaligned_102", 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0102, $urandom, 5'd13, 2, 32'h2468_ACE0);
        run_alu("post_misaligned", 1'b1, 1'b0, 32'h0000_0099, 5'd14, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_mem("b2b_a", 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0700, $urandom, 5'd15, 1, $urandom);
        run_mem("b2b_b", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0704, $urandom, 5'd16, 1, $urandom);
        run_mem("b2b_c", 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0708, $urandom, 5'd17, 3, $urandom);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic        mr, mw;
        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                run_alu("rand_alu", 1'($urandom), 1'($urandom), $urandom, 5'($urandom), 1'($urandom));
            end else begin
                a = $urandom;
                if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
                mr = 1'($urandom);
                mw = mr ? 1'($urandom) : 1'b1;
                run_mem("rand_mem", mr, mw, 1'($urandom), 1'($urandom), a, $urandom,
                        5'($urandom), $urandom_range(0, MAXW), $urandom);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_load();
        test_store();
        test_timeout();
        test_reset_mid_req();
        test_misaligned();
        test_back_to_back();
        test_random();
        run_alu("final", 1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
